// File: rtl/round_ctrl_pkg.sv
// Shared definitions for the gold-miner round sequencer and its timer.
// State encoding is 3 bits; code 3'd7 is unused and recovers to IDLE.
package round_ctrl_pkg;

  localparam int SCORE_W_DEFAULT = 12;
  localparam int ROUND_SECONDS   = 45;
  localparam int LEVEL_W         = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5,
    DONE  = 3'd6
  } round_state_e;

  function automatic logic [31:0] level_target(input int unsigned base,
                                               input int unsigned step,
                                               input logic [LEVEL_W-1:0] lvl);
    return base + step * {29'd0, lvl};
  endfunction

endpackage

// File: rtl/round_ctrl_edge_detect.sv
// Rising-edge detector for a debounced button, reusable for any level input.
// A button already held when reset releases must be let go before it can fire.
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sig_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
      if (!sig_i) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise_o = sig_i & ~sig_q & armed_q;

endmodule

// File: rtl/round_ctrl.sv
// Game-round sequencer: runs the countdown timer per level, judges the score
// against the level target at round end, and advances, ends or wins the game.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int NUM_LEVELS  = 5,
  parameter int SCORE_W     = SCORE_W_DEFAULT,
  parameter int BASE_TARGET = 100,
  parameter int TARGET_STEP = 75
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               time_done,
  input  logic [SCORE_W-1:0] score,
  output logic               timer_enable,
  output logic               score_clear,
  output logic               level_load,
  output logic [2:0]         level,
  output logic [SCORE_W-1:0] target,
  output logic               round_active,
  output logic               level_won,
  output logic               game_over,
  output logic               game_won
);

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  round_state_e       state_q;
  logic [LEVEL_W-1:0] level_q;
  logic               timer_enable_q;
  logic               score_clear_q;
  logic               level_load_q;
  logic               start_rise;
  logic [31:0]        target_full;

  edge_detect u_start_edge (
    .clk    (clk),
    .resetn (resetn),
    .sig_i  (start),
    .rise_o (start_rise)
  );

  assign target_full = level_target(BASE_TARGET, TARGET_STEP, level_q);
  assign target      = target_full[SCORE_W-1:0];

  // timer_enable lags PLAY entry by one cycle so it rises after level_load.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      level_q        <= '0;
      timer_enable_q <= 1'b0;
      score_clear_q  <= 1'b0;
      level_load_q   <= 1'b0;
    end else begin
      score_clear_q  <= 1'b0;
      level_load_q   <= 1'b0;
      timer_enable_q <= (state_q == PLAY) && !time_done;
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q       <= LOAD;
            level_q       <= '0;
            score_clear_q <= 1'b1;
          end
        end
        LOAD: begin
          state_q      <= PLAY;
          level_load_q <= 1'b1;
        end
        PLAY: begin
          if (time_done) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (score >= target) begin
            state_q <= (level_q >= LAST_LEVEL) ? DONE : WIN;
          end else begin
            state_q <= LOSE;
          end
        end
        WIN: begin
          if (start_rise) begin
            state_q <= LOAD;
            if (level_q < LAST_LEVEL) begin
              level_q <= level_q + 1'b1;
            end
          end
        end
        LOSE, DONE: begin
          if (start_rise) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q        <= IDLE;
          timer_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign timer_enable = timer_enable_q;
  assign score_clear  = score_clear_q;
  assign level_load   = level_load_q;
  assign level        = level_q;
  assign round_active = (state_q == PLAY);
  assign level_won    = (state_q == WIN);
  assign game_over    = (state_q == LOSE);
  assign game_won     = (state_q == DONE);

endmodule

// File: tb/tb_round_ctrl.sv
// Randomized scoreboard bench for round_ctrl: a game-level model predicts
// pulse and round-result events, and a monitor pops and compares them.
module tb_round_ctrl;

  localparam int NUM_LEVELS  = 5;
  localparam int SCORE_W     = 12;
  localparam int BASE_TARGET = 100;
  localparam int TARGET_STEP = 75;

  localparam int EV_CLEAR = 0;
  localparam int EV_LOAD  = 1;
  localparam int EV_WIN   = 2;
  localparam int EV_LOSE  = 3;
  localparam int EV_DONE  = 4;

  typedef struct {
    int kind;
    int level;
  } expEvent_t;

  typedef enum int {M_IDLE, M_PLAY, M_WON, M_LOST, M_DONE} modelState_e;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic               timeDone = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic               timerEnable;
  logic               scoreClear;
  logic               levelLoad;
  logic [2:0]         level;
  logic [SCORE_W-1:0] target;
  logic               roundActive;
  logic               levelWon;
  logic               gameOver;
  logic               gameWon;

  expEvent_t   expQ[$];
  int          checks = 0;
  int          errors = 0;
  modelState_e mState = M_IDLE;
  int          mLevel = 0;
  bit          monEnable = 1'b0;
  bit          prevWon = 1'b0;
  bit          prevOver = 1'b0;
  bit          prevDone = 1'b0;

  round_ctrl #(
    .NUM_LEVELS  (NUM_LEVELS),
    .SCORE_W     (SCORE_W),
    .BASE_TARGET (BASE_TARGET),
    .TARGET_STEP (TARGET_STEP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .time_done    (timeDone),
    .score        (score),
    .timer_enable (timerEnable),
    .score_clear  (scoreClear),
    .level_load   (levelLoad),
    .level        (level),
    .target       (target),
    .round_active (roundActive),
    .level_won    (levelWon),
    .game_over    (gameOver),
    .game_won     (gameWon)
  );

  always #5 clk = ~clk;

  function automatic int targetFor(input int lvl);
    return (BASE_TARGET + lvl * TARGET_STEP) % (1 << SCORE_W);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic handleEvent(input int kind);
    expEvent_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d, expected none at %0t", kind, $time);
    end else begin
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_level", int'(level), e.level);
      checkOutput("event_target", int'(target), targetFor(e.level));
    end
  endtask

  // Monitor: every pulse or newly raised status is a DUT event to be matched.
  always @(negedge clk) begin
    if (monEnable) begin
      if (scoreClear) handleEvent(EV_CLEAR);
      if (levelLoad) handleEvent(EV_LOAD);
      if (levelWon && !prevWon) handleEvent(EV_WIN);
      if (gameOver && !prevOver) handleEvent(EV_LOSE);
      if (gameWon && !prevDone) handleEvent(EV_DONE);
      prevWon  = levelWon;
      prevOver = gameOver;
      prevDone = gameWon;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag, input int expLevel);
    checkOutput({tag, "_timer_enable"}, int'(timerEnable), 0);
    checkOutput({tag, "_round_active"}, int'(roundActive), 0);
    checkOutput({tag, "_status"}, int'({levelWon, gameOver, gameWon}), 0);
    checkOutput({tag, "_pulses"}, int'({scoreClear, levelLoad}), 0);
    checkOutput({tag, "_level"}, int'(level), expLevel);
    checkOutput({tag, "_target"}, int'(target), targetFor(expLevel));
  endtask

  // One clean press; the model predicts which events it causes.
  task automatic applyStimulus();
    bit entersPlay;
    @(negedge clk);
    start = 1'b1;
    entersPlay = 1'b0;
    case (mState)
      M_IDLE: begin
        mLevel = 0;
        expQ.push_back('{EV_CLEAR, 0});
        expQ.push_back('{EV_LOAD, 0});
        mState = M_PLAY;
        entersPlay = 1'b1;
      end
      M_WON: begin
        mLevel++;
        expQ.push_back('{EV_LOAD, mLevel});
        mState = M_PLAY;
        entersPlay = 1'b1;
      end
      M_LOST, M_DONE: mState = M_IDLE;
      default: ;
    endcase
    @(negedge clk);
    start = 1'b0;
    if (entersPlay) begin
      checkOutput("timer_off_load", int'(timerEnable), 0);
      @(negedge clk);
      checkOutput("timer_off_levelload", int'(timerEnable), 0);
      @(negedge clk);
      checkOutput("timer_on_play", int'(timerEnable), 1);
      checkOutput("round_active_play", int'(roundActive), 1);
      checkOutput("play_level", int'(level), mLevel);
      checkOutput("play_target", int'(target), targetFor(mLevel));
    end else if (mState == M_IDLE) begin
      checkIdleOutputs("back_to_idle", mLevel);
    end
  endtask

  // Churn the score in PLAY, end the round, present the judged score in CHECK.
  task automatic playRound(input int finalScore);
    int n;
    int tgt;
    n = $urandom_range(1, 8);
    repeat (n) begin
      @(negedge clk);
      score = SCORE_W'($urandom_range(0, (1 << SCORE_W) - 1));
    end
    @(negedge clk);
    timeDone = 1'b1;
    score = SCORE_W'($urandom_range(0, (1 << SCORE_W) - 1));
    @(negedge clk);
    timeDone = 1'b0;
    score = SCORE_W'(finalScore);
    checkOutput("timer_fall", int'(timerEnable), 0);
    checkOutput("round_active_check", int'(roundActive), 0);
    tgt = targetFor(mLevel);
    if (finalScore >= tgt) begin
      if (mLevel == NUM_LEVELS - 1) begin
        expQ.push_back('{EV_DONE, mLevel});
        mState = M_DONE;
      end else begin
        expQ.push_back('{EV_WIN, mLevel});
        mState = M_WON;
      end
    end else begin
      expQ.push_back('{EV_LOSE, mLevel});
      mState = M_LOST;
    end
    @(negedge clk);
    score = SCORE_W'($urandom_range(0, (1 << SCORE_W) - 1));
    checkOutput("result_level_won", int'(levelWon), (mState == M_WON) ? 1 : 0);
    checkOutput("result_game_over", int'(gameOver), (mState == M_LOST) ? 1 : 0);
    checkOutput("result_game_won", int'(gameWon), (mState == M_DONE) ? 1 : 0);
    checkOutput("result_timer", int'(timerEnable), 0);
    checkOutput("result_level", int'(level), mLevel);
  endtask

  // time_done pulses outside PLAY must be ignored.
  task automatic idleNoise();
    int n;
    n = $urandom_range(0, 4);
    repeat (n) begin
      @(negedge clk);
      timeDone = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    timeDone = 1'b0;
  endtask

  function automatic int pickScore();
    int tgt;
    int r;
    tgt = targetFor(mLevel);
    r = $urandom_range(0, 9);
    if (r < 2) return tgt - 1;
    if (r < 4) return tgt;
    if (r < 8) return tgt + $urandom_range(1, 300);
    return $urandom_range(0, tgt - 1);
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    waitCycles(3);
    checkIdleOutputs("reset", 0);
    resetn = 1'b1;
    monEnable = 1'b1;
    waitCycles(3);

    // Level 0 exactly on target, then a near-miss on level 2.
    applyStimulus();
    playRound(100);
    applyStimulus();
    playRound(targetFor(1) + 10);
    applyStimulus();
    playRound(249);
    idleNoise();
    applyStimulus();
    applyStimulus();

    // Full game on exact targets, finishing in DONE at the last level.
    for (int l = 0; l < NUM_LEVELS; l++) begin
      playRound(targetFor(mLevel));
      if (mState == M_WON) applyStimulus();
    end
    waitCycles(3);
    checkOutput("done_level_held", int'(level), NUM_LEVELS - 1);
    checkOutput("done_status_held", int'(gameWon), 1);
    applyStimulus();

    for (int g = 0; g < 12; g++) begin
      waitCycles($urandom_range(1, 3));
      applyStimulus();
      while (mState == M_PLAY) begin
        playRound(pickScore());
        idleNoise();
        applyStimulus();
      end
    end

    // Start held through PLAY and the loss; only a fresh press moves on.
    applyStimulus();
    @(negedge clk);
    start = 1'b1;
    waitCycles(4);
    playRound(0);
    waitCycles(4);
    checkOutput("held_start_still_lose", int'(gameOver), 1);
    start = 1'b0;
    waitCycles(2);
    applyStimulus();
    repeat (3) begin
      @(negedge clk);
      timeDone = 1'b1;
    end
    @(negedge clk);
    timeDone = 1'b0;
    checkIdleOutputs("idle_time_done", mLevel);
    applyStimulus();

    // Reach level 3 then reset in the middle of the round.
    for (int l = 0; l < 3; l++) begin
      playRound(targetFor(mLevel) + 5);
      applyStimulus();
    end
    waitCycles(3);
    @(negedge clk);
    resetn = 1'b0;
    mState = M_IDLE;
    mLevel = 0;
    @(negedge clk);
    checkIdleOutputs("mid_round_reset", 0);
    resetn = 1'b1;
    waitCycles(3);

    // A press held across reset release must not start a game.
    @(negedge clk);
    start = 1'b1;
    resetn = 1'b0;
    waitCycles(2);
    resetn = 1'b1;
    waitCycles(5);
    checkIdleOutputs("held_through_reset", 0);
    start = 1'b0;
    waitCycles(2);
    applyStimulus();
    playRound(0);
    applyStimulus();

    waitCycles(5);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
